gf180mcu_osu_sc_9t_clkdiv_prog: RTL and testbench



---
 rtl/gf180mcu_osu_sc_clkdiv_pkg.sv | 32 +++
 rtl/gf180mcu_osu_sc_clkdiv_chan.sv | 127 ++++++++++++
 rtl/gf180mcu_osu_sc_9t_clkdiv_prog.sv | 41 ++++
 tb/tb_gf180mcu_osu_sc_9t_clkdiv_prog.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_osu_sc_clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gf180mcu_osu_sc_clkdiv_pkg;

  // Default width of one channel's divide ratio.
  localparam int DIVW_DEF = 8;

  // Channel run state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Effective period and high-phase length derived from a raw ratio.
  // Both fields are 32 bits wide so every channel width up to 31 fits.
  typedef struct packed {
    logic [31:0] d;   // period in source cycles
    logic [31:0] hi;  // high cycles; odd periods get the extra cycle
  } ratio_t;

  // Ratios 0 and 1 both map to a period of 2. A ratio of 0 never reaches
  // the running logic, because it parks the channel in IDLE, so that
  // mapping only keeps the arithmetic free of underflow.
  function automatic ratio_t eff_ratio(input logic [31:0] raw);
    ratio_t r;
    r.d  = (raw < 32'd2) ? 32'd2 : raw;
    r.hi = r.d - (r.d >> 1);
    return r;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_clkdiv_chan.sv
// One divider channel: IDLE/RUN control, period counter, shadow ratio, output flop.
// Latency: the output changes one cycle after the controlling input is sampled.
// Backpressure: none; ratio and inversion changes wait for the period boundary.
module gf180mcu_osu_sc_clkdiv_chan
  import gf180mcu_osu_sc_clkdiv_pkg::*;
#(
  parameter int DIVW    = DIVW_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            inv_i,
  input  logic            load_i,
  input  logic [DIVW-1:0] div_i,
  output logic            y_o,
  output logic            act_o,
  output logic            pend_o
);

  state_e          state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] d_act_q, d_act_d;
  logic [DIVW-1:0] d_shd_q, d_shd_d;
  logic            pend_q, pend_d;
  logic            inv_q, inv_d;
  logic            y_q, y_d;

  // The raw clock phase is never stored on its own. Only its XOR with the
  // inversion bit is registered, so the output comes from a single flop.
  logic            yraw_d;

  ratio_t          rat;
  logic            wrap;
  logic [DIVW-1:0] cnt_nxt;
  logic            phase_hi;

  // Decode the active ratio and the period position. Comparisons are made
  // at 32 bits, so a ratio of 2^DIVW-1 is handled without wrap-around.
  always_comb begin
    rat      = eff_ratio(32'(d_act_q));
    wrap     = (32'(cnt_q) == (rat.d - 32'd1));
    cnt_nxt  = wrap ? '0 : (cnt_q + DIVW'(1));
    phase_hi = (32'(cnt_nxt) < rat.hi);
  end

  // Next-state logic. Every ratio, inversion and stop decision taken while
  // running waits for the wrap cycle, so a period is never cut short.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_act_d = d_act_q;
    d_shd_d = d_shd_q;
    pend_d  = pend_q;
    inv_d   = inv_q;
    yraw_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        inv_d = inv_i;
        if (load_i) begin
          d_act_d = div_i;
        end
        // The start decision uses the ratio being loaded in this same cycle.
        if (en_i && (d_act_d != '0)) begin
          state_d = ST_RUN;
          yraw_d  = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d  = cnt_nxt;
        yraw_d = phase_hi;
        if (wrap) begin
          // A LOAD on the wrap cycle goes straight to the active ratio and
          // replaces any older shadow value.
          if (load_i) begin
            d_act_d = div_i;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            d_act_d = d_shd_q;
            pend_d  = 1'b0;
          end
          inv_d = inv_i;
          if (!en_i || (d_act_d == '0)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            yraw_d  = 1'b0;
          end
        end else if (load_i) begin
          d_shd_d = div_i;
          pend_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    y_d = yraw_d ^ inv_d;
  end

  // State registers. Reset is synchronous and discards any pending ratio.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_act_q <= DIVW'(DEF_DIV);
      d_shd_q <= DIVW'(DEF_DIV);
      pend_q  <= 1'b0;
      inv_q   <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_act_q <= d_act_d;
      d_shd_q <= d_shd_d;
      pend_q  <= pend_d;
      inv_q   <= inv_d;
      y_q     <= y_d;
    end
  end

  assign y_o    = y_q;
  assign act_o  = (state_q != ST_IDLE);
  assign pend_o = pend_q;

endmodule

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_prog.sv
// Multi-channel programmable clock divider with glitch-free registered outputs.
// Latency: each channel's Y follows its controls one cycle after they are sampled.
// Backpressure: none; LOAD is a one-cycle strobe and deferred ratios wait in the shadow register.
module gf180mcu_osu_sc_9t_clkdiv_prog
  import gf180mcu_osu_sc_clkdiv_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIVW    = DIVW_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NCH-1:0]      EN,
  input  logic [NCH-1:0]      INV,
  input  logic [NCH*DIVW-1:0] DIV,
  input  logic                LOAD,
  output logic [NCH-1:0]      Y,
  output logic [NCH-1:0]      ACT,
  output logic [NCH-1:0]      PEND
);

  // Independent channels. Each one gets its own ratio slice, and all of
  // them share the same LOAD strobe.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    gf180mcu_osu_sc_clkdiv_chan #(
      .DIVW   (DIVW),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (EN[c]),
      .inv_i (INV[c]),
      .load_i(LOAD),
      .div_i (DIV[c*DIVW +: DIVW]),
      .y_o   (Y[c]),
      .act_o (ACT[c]),
      .pend_o(PEND[c])
    );
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_clkdiv_prog.sv
module tb_gf180mcu_osu_sc_9t_clkdiv_prog;
  localparam int NCH  = 4;
  localparam int DIVW = 8;

  logic                CLK = 1'b0;
  logic                RST;
  logic                LOAD;
  logic [NCH-1:0]      EN, INV, Y, ACT, PEND;
  logic [NCH*DIVW-1:0] DIV;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_9t_clkdiv_prog #(.NCH(NCH), .DIVW(DIVW), .DEF_DIV(2)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .INV (INV),
    .DIV (DIV),
    .LOAD(LOAD),
    .Y   (Y),
    .ACT (ACT),
    .PEND(PEND)
  );

  task automatic check(input string name, input logic [3*NCH-1:0] got, input logic [3*NCH-1:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: Y/ACT/PEND got %b required %b", name, got, req);
    end
  endtask

  // Channel-0 vectors: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic rst, en, inv, ld;
    logic [7:0] div;
    logic y, act, pend;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rst, en, inv, ld, input logic [7:0] div,
                              input logic y, act, pend);
    vec_t v;
    v.rst = rst; v.en = en; v.inv = inv; v.ld = ld; v.div = div;
    v.y = y; v.act = act; v.pend = pend;
    tbl.push_back(v);
  endfunction

  // Reference model: each running period is expanded into a queue of
  // output levels, one entry per cycle. The period wraps when the last
  // entry is consumed.
  bit m_run  [NCH];
  bit m_q    [NCH][$];
  int m_dact [NCH];
  int m_dshd [NCH];
  bit m_pend [NCH];
  bit m_inv  [NCH];

  task automatic start_period(input int c);
    int d;
    d = (m_dact[c] < 2) ? 2 : m_dact[c];
    m_q[c].delete();
    for (int i = 0; i < d; i++) m_q[c].push_back(i < (d - d / 2));
    m_run[c] = 1'b1;
  endtask

  task automatic model_step(input logic rst, input logic [NCH-1:0] en, input logic [NCH-1:0] inv,
                            input logic ld, input logic [NCH*DIVW-1:0] div);
    for (int c = 0; c < NCH; c++) begin
      int field;
      bit last, b;
      field = int'(div[c*DIVW +: DIVW]);
      if (rst) begin
        m_run[c] = 0; m_q[c].delete(); m_dact[c] = 2; m_dshd[c] = 2;
        m_pend[c] = 0; m_inv[c] = 0;
      end else if (!m_run[c]) begin
        m_inv[c] = inv[c];
        if (ld) m_dact[c] = field;
        if (en[c] && m_dact[c] != 0) start_period(c);
      end else begin
        last = (m_q[c].size() == 1);
        b = m_q[c].pop_front();
        if (last) begin
          if (ld) begin
            m_dact[c] = field; m_pend[c] = 0;
          end else if (m_pend[c]) begin
            m_dact[c] = m_dshd[c]; m_pend[c] = 0;
          end
          m_inv[c] = inv[c];
          if (en[c] && m_dact[c] != 0) start_period(c);
          else m_run[c] = 0;
        end else if (ld) begin
          m_dshd[c] = field; m_pend[c] = 1;
        end
      end
    end
  endtask

  function automatic logic [3*NCH-1:0] model_out();
    logic [NCH-1:0] y, a, p;
    for (int c = 0; c < NCH; c++) begin
      y[c] = (m_run[c] ? m_q[c][0] : 1'b0) ^ m_inv[c];
      a[c] = m_run[c];
      p[c] = m_pend[c];
    end
    return {y, a, p};
  endfunction

  initial begin
    logic [NCH-1:0] en_r, inv_r;
    bit done;
    RST = 1'b1; EN = '0; INV = '0; LOAD = 1'b0; DIV = '0;

    // Reset with EN high, then the default ratio of 2.
    for (int i = 0; i < 3; i++) add(1,1,0,0,0, 0,0,0);
    add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 0,1,0); add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 0,1,0);
    add(0,0,0,0,0, 0,0,0);
    // Odd ratio 5 loaded while idle.
    add(0,0,0,1,5, 0,0,0);
    add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 1,1,0);
    add(0,1,0,0,0, 0,1,0); add(0,1,0,0,0, 0,1,0);
    add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 1,1,0);
    // LOAD 4 at cnt=1: pending for three cycles, then a period of 4.
    add(0,1,0,1,4, 1,1,1); add(0,1,0,0,0, 0,1,1); add(0,1,0,0,0, 0,1,1);
    add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 0,1,0); add(0,1,0,0,0, 0,1,0);
    add(0,1,0,0,0, 1,1,0);
    // Move to ratio 6, then drop EN at cnt=2.
    add(0,1,0,1,6, 1,1,1); add(0,1,0,0,0, 0,1,1); add(0,1,0,0,0, 0,1,1);
    add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 1,1,0);
    add(0,0,0,0,0, 0,1,0); add(0,0,0,0,0, 0,1,0); add(0,0,0,0,0, 0,1,0);
    add(0,0,0,0,0, 0,0,0); add(0,0,0,0,0, 0,0,0);
    // Inversion while idle, then INV toggled in the middle of a period.
    add(0,0,1,0,0, 1,0,0); add(0,0,0,0,0, 0,0,0); add(0,0,1,0,0, 1,0,0);
    add(0,0,0,1,4, 0,0,0);
    add(0,1,0,0,0, 1,1,0); add(0,1,1,0,0, 1,1,0); add(0,1,1,0,0, 0,1,0); add(0,1,1,0,0, 0,1,0);
    add(0,1,1,0,0, 0,1,0); add(0,1,1,0,0, 0,1,0); add(0,1,1,0,0, 1,1,0); add(0,1,0,0,0, 1,1,0);
    add(0,1,0,0,0, 1,1,0);
    add(0,0,0,0,0, 1,1,0); add(0,0,0,0,0, 0,1,0); add(0,0,0,0,0, 0,1,0); add(0,0,0,0,0, 0,0,0);
    // Ratio 0 holds the channel idle with Y = INV.
    add(0,0,0,1,0, 0,0,0); add(0,1,1,0,0, 1,0,0); add(0,1,0,0,0, 0,0,0);
    // Ratio 1 behaves as ratio 2. A pending ratio is then dropped by reset.
    add(0,0,0,1,1, 0,0,0);
    add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 0,1,0); add(0,1,0,0,0, 1,1,0);
    add(0,1,0,1,3, 0,1,1);
    add(1,1,0,0,0, 0,0,0); add(0,0,0,0,0, 0,0,0);
    add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 0,1,0); add(0,1,0,0,0, 1,1,0); add(0,1,0,0,0, 0,1,0);
    add(0,0,0,0,0, 0,0,0);

    foreach (tbl[i]) begin
      RST = tbl[i].rst; EN = {3'b000, tbl[i].en}; INV = {3'b000, tbl[i].inv};
      LOAD = tbl[i].ld; DIV = {24'd0, tbl[i].div};
      @(posedge CLK); #1;
      check($sformatf("vec%0d", i), {Y, ACT, PEND},
            {3'b000, tbl[i].y, 3'b000, tbl[i].act, 3'b000, tbl[i].pend});
    end

    // Largest ratio on channel 1: 128 high cycles, 127 low, then high again.
    RST = 0; EN = '0; INV = '0; LOAD = 1; DIV = {8'd0, 8'd0, 8'd255, 8'd0};
    @(posedge CLK); #1;
    LOAD = 0; DIV = '0; EN = 4'b0010;
    for (int i = 0; i < 256; i++) begin
      @(posedge CLK); #1;
      check($sformatf("max_ratio_cyc%0d", i), {Y, ACT, PEND},
            {2'b00, ((i % 255) < 128), 1'b0, 4'b0010, 4'b0000});
    end
    EN = '0;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge CLK); #1;
      if (ACT == '0) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL max_ratio_stop: ACT still %b after 300 cycles, required 0000", ACT);
    end

    // LOAD on the wrap cycle takes effect at once, and PEND stays low.
    LOAD = 1; DIV = {8'd0, 8'd3, 8'd0, 8'd0};
    @(posedge CLK); #1;
    LOAD = 0; DIV = '0; EN = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check($sformatf("wrapload_pre%0d", i), {Y, ACT, PEND}, {1'b0, (i < 2), 2'b00, 4'b0100, 4'b0000});
      if (i == 2) begin
        LOAD = 1; DIV = {8'd0, 8'd5, 8'd0, 8'd0};
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      LOAD = 0; DIV = '0;
      check($sformatf("wrapload_post%0d", i), {Y, ACT, PEND},
            {1'b0, ((i % 5) < 3), 2'b00, 4'b0100, 4'b0000});
    end

    // Randomized run against the reference model on all channels.
    RST = 1; EN = '0; INV = '0; LOAD = 0; DIV = '0;
    @(posedge CLK);
    model_step(RST, EN, INV, LOAD, DIV);
    #1;
    check("rand_reset", {Y, ACT, PEND}, model_out());
    en_r = '1; inv_r = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0) en_r[c] = ~en_r[c];
        if ($urandom_range(0, 11) == 0) inv_r[c] = ~inv_r[c];
        DIV[c*DIVW +: DIVW] = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(200, 255))
                                                            : 8'($urandom_range(0, 7));
      end
      RST  = ($urandom_range(0, 599) == 0);
      LOAD = ($urandom_range(0, 7) == 0);
      EN = en_r; INV = inv_r;
      @(posedge CLK);
      model_step(RST, EN, INV, LOAD, DIV);
      #1;
      check($sformatf("rand%0d", n), {Y, ACT, PEND}, model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
